// File: rtl/axi_master_wrapper.sv
// CPU-side request to AXI4 master bridge: one outstanding transaction,
// INCR read bursts of 1..16 beats and single-beat writes, completion via rsp_done.
module axi_master_wrapper #(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = 4'd0,
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              LEN_W     = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // CPU request side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_rvalid,
    output logic                  rsp_done,
    output logic                  rsp_err,
    // AXI write address channel
    output logic [ID_W-1:0]       M_AWID,
    output logic [ADDR_W-1:0]     M_AWADDR,
    output logic [LEN_W-1:0]      M_AWLEN,
    output logic [2:0]            M_AWSIZE,
    output logic [1:0]            M_AWBURST,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    // AXI write data channel
    output logic [DATA_W-1:0]     M_WDATA,
    output logic [DATA_W/8-1:0]   M_WSTRB,
    output logic                  M_WLAST,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    // AXI write response channel
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    // AXI read address channel
    output logic [ID_W-1:0]       M_ARID,
    output logic [ADDR_W-1:0]     M_ARADDR,
    output logic [LEN_W-1:0]      M_ARLEN,
    output logic [2:0]            M_ARSIZE,
    output logic [1:0]            M_ARBURST,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    // AXI read data channel
    input  logic [DATA_W-1:0]     M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RLAST,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);

    localparam int          STRB_W     = DATA_W / 8;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [2:0]  SIZE_4B    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4,
        ST_WRESP = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [LEN_W-1:0]    len_q,   len_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [LEN_W-1:0]    cnt_q,   cnt_d;
    logic                err_q,   err_d;
    logic                beat_err;

    // Payloads come straight from the request latch, so they stay stable while valid is up
    assign M_AWID    = MASTER_ID;
    assign M_AWADDR  = addr_q;
    assign M_AWLEN   = {LEN_W{1'b0}};
    assign M_AWSIZE  = SIZE_4B;
    assign M_AWBURST = BURST_INCR;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WLAST   = 1'b1;
    assign M_ARID    = MASTER_ID;
    assign M_ARADDR  = addr_q;
    assign M_ARLEN   = len_q;
    assign M_ARSIZE  = SIZE_4B;
    assign M_ARBURST = BURST_INCR;

    // Next-state, request latch, beat counting and channel handshakes
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        beat_err   = 1'b0;
        req_ready  = 1'b0;
        rsp_rvalid = 1'b0;
        rsp_rdata  = {DATA_W{1'b0}};
        rsp_done   = 1'b0;
        rsp_err    = 1'b0;
        M_AWVALID  = 1'b0;
        M_WVALID   = 1'b0;
        M_BREADY   = 1'b0;
        M_ARVALID  = 1'b0;
        M_RREADY   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    len_d   = req_len;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = {LEN_W{1'b0}};
                    err_d   = 1'b0;
                    state_d = req_write ? ST_WADDR : ST_RADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RADDR: begin
                M_ARVALID = 1'b1;
                if (M_ARREADY) begin
                    state_d = ST_RDATA;
                end else begin
                    state_d = ST_RADDR;
                end
            end
            ST_RDATA: begin
                M_RREADY = 1'b1;
                if (M_RVALID) begin
                    rsp_rvalid = 1'b1;
                    rsp_rdata  = M_RDATA;
                    // Flags early RLAST as well as a missing RLAST on the expected last beat
                    beat_err   = (M_RRESP != RESP_OKAY) || (M_RLAST != (cnt_q == len_q));
                    err_d      = err_q | beat_err;
                    if (cnt_q != {LEN_W{1'b1}}) begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (M_RLAST) begin
                        rsp_done = 1'b1;
                        rsp_err  = err_q | beat_err;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_RDATA;
                    end
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_WADDR: begin
                M_AWVALID = 1'b1;
                if (M_AWREADY) begin
                    state_d = ST_WDATA;
                end else begin
                    state_d = ST_WADDR;
                end
            end
            ST_WDATA: begin
                M_WVALID = 1'b1;
                if (M_WREADY) begin
                    state_d = ST_WRESP;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_WRESP: begin
                M_BREADY = 1'b1;
                if (M_BVALID) begin
                    beat_err = (M_BRESP != RESP_OKAY);
                    err_d    = err_q | beat_err;
                    rsp_done = 1'b1;
                    rsp_err  = err_q | beat_err;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_WRESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers with synchronous active-low reset
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            wstrb_q <= {STRB_W{1'b0}};
            cnt_q   <= {LEN_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_master_wrapper.sv
// Directed bench for axi_master_wrapper: the bench plays the AXI slave cycle by cycle
// and compares every observed output against hand-derived expectations.
module tb_axi_master_wrapper;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] rsp_rdata;
    logic        rsp_rvalid, rsp_done, rsp_err;
    logic [3:0]  M_AWID, M_AWLEN, M_ARID, M_ARLEN;
    logic [31:0] M_AWADDR, M_ARADDR, M_WDATA, M_RDATA;
    logic [2:0]  M_AWSIZE, M_ARSIZE;
    logic [1:0]  M_AWBURST, M_ARBURST, M_BRESP, M_RRESP;
    logic        M_AWVALID, M_AWREADY, M_WLAST, M_WVALID, M_WREADY;
    logic [3:0]  M_WSTRB;
    logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY;
    logic        M_RLAST, M_RVALID, M_RREADY;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ACLK = ~ACLK;

    axi_master_wrapper dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_rdata(rsp_rdata), .rsp_rvalid(rsp_rvalid), .rsp_done(rsp_done), .rsp_err(rsp_err),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
        .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RVALID(M_RVALID),
        .M_RREADY(M_RREADY)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_slave();
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = 2'b00;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00;
        M_RDATA = 32'h0;
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
        req_wdata = wdata; req_wstrb = wstrb;
    endtask

    // Read: accept, ARREADY raised on the ar_wait-th AR cycle, nbeats beats of base+i,
    // RLAST on the final supplied beat, optional one-cycle gap before every beat after the first
    task automatic run_read(input logic [31:0] addr, input logic [3:0] len, input int ar_wait,
                            input int nbeats, input logic [31:0] base, input logic gap,
                            input logic exp_err);
        drive_req(1'b0, addr, len, 32'h0, 4'h0);
        #1 check_val("rd_req_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        #1;
        check_val("rd_arlen", M_ARLEN, len);
        check_val("rd_arburst", M_ARBURST, 2'b01);
        check_val("rd_arsize", M_ARSIZE, 3'b010);
        check_val("rd_arid", M_ARID, 4'd0);
        check_val("rd_busy", req_ready, 1'b0);
        for (int w = 0; w < ar_wait; w++) begin
            M_ARREADY = (w == ar_wait - 1);
            #1;
            check_val("rd_arvalid", M_ARVALID, 1'b1);
            check_val("rd_araddr", M_ARADDR, addr);
            check_val("rd_no_aw", M_AWVALID, 1'b0);
            tick();
        end
        M_ARREADY = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (gap && b > 0) begin
                M_RVALID = 1'b0;
                #1;
                check_val("rd_gap_rvalid", rsp_rvalid, 1'b0);
                check_val("rd_rready", M_RREADY, 1'b1);
                tick();
            end
            M_RVALID = 1'b1;
            M_RDATA  = base + 32'(b);
            M_RLAST  = (b == nbeats - 1);
            #1;
            check_val("rd_arvalid_low", M_ARVALID, 1'b0);
            check_val("rd_rsp_rvalid", rsp_rvalid, 1'b1);
            check_val("rd_rsp_rdata", rsp_rdata, base + 32'(b));
            check_val("rd_rsp_done", rsp_done, (b == nbeats - 1));
            if (b == nbeats - 1) begin
                check_val("rd_rsp_err", rsp_err, exp_err);
            end
            tick();
        end
        clear_slave();
        #1;
        check_val("rd_idle_ready", req_ready, 1'b1);
        check_val("rd_idle_done", rsp_done, 1'b0);
        check_val("rd_idle_rready", M_RREADY, 1'b0);
    endtask

    // Write: AWREADY on the aw_wait-th AW cycle, WREADY at once, BVALID on the b_wait-th cycle
    task automatic run_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_wait, input int b_wait, input logic [1:0] bresp,
                             input logic exp_err);
        drive_req(1'b1, addr, 4'hF, data, strb);
        #1 check_val("wr_req_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        for (int w = 0; w < aw_wait; w++) begin
            M_AWREADY = (w == aw_wait - 1);
            #1;
            check_val("wr_awvalid", M_AWVALID, 1'b1);
            check_val("wr_awaddr", M_AWADDR, addr);
            check_val("wr_awlen", M_AWLEN, 4'd0);
            check_val("wr_w_before_aw", M_WVALID, 1'b0);
            check_val("wr_no_ar", M_ARVALID, 1'b0);
            tick();
        end
        M_AWREADY = 1'b0;
        M_WREADY  = 1'b1;
        #1;
        check_val("wr_wvalid", M_WVALID, 1'b1);
        check_val("wr_wlast", M_WLAST, 1'b1);
        check_val("wr_wdata", M_WDATA, data);
        check_val("wr_wstrb", M_WSTRB, strb);
        check_val("wr_awvalid_low", M_AWVALID, 1'b0);
        tick();
        M_WREADY = 1'b0;
        for (int b = 0; b < b_wait; b++) begin
            M_BVALID = (b == b_wait - 1);
            M_BRESP  = bresp;
            #1;
            check_val("wr_wvalid_low", M_WVALID, 1'b0);
            check_val("wr_bready", M_BREADY, 1'b1);
            check_val("wr_done", rsp_done, (b == b_wait - 1));
            if (b == b_wait - 1) begin
                check_val("wr_err", rsp_err, exp_err);
            end
            tick();
        end
        clear_slave();
        #1;
        check_val("wr_idle_ready", req_ready, 1'b1);
        check_val("wr_idle_bready", M_BREADY, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ARESETn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_len = 4'h0;
        req_wdata = 32'h0; req_wstrb = 4'h0;
        clear_slave();
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        #1;
        check_val("rst_req_ready", req_ready, 1'b1);
        check_val("rst_arvalid", M_ARVALID, 1'b0);
        check_val("rst_awvalid", M_AWVALID, 1'b0);
        check_val("rst_wvalid", M_WVALID, 1'b0);
        check_val("rst_bready", M_BREADY, 1'b0);
        check_val("rst_rready", M_RREADY, 1'b0);
        check_val("rst_done", rsp_done, 1'b0);

        // single-beat read, AR held two cycles
        run_read(32'h0000_0010, 4'd0, 2, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // four-beat read with RVALID gaps
        run_read(32'h0000_0100, 4'd3, 1, 4, 32'h1, 1'b1, 1'b0);
        // write with AWREADY held off three cycles
        run_write(32'h0000_0020, 32'h1234_5678, 4'b0011, 4, 2, 2'b00, 1'b0);
        // SLVERR write response, then error cleared by the next clean write
        run_write(32'h0000_0024, 32'hA5A5_0000, 4'b1111, 1, 1, 2'b10, 1'b1);
        run_write(32'h0000_0028, 32'h0000_5A5A, 4'b1100, 1, 1, 2'b00, 1'b0);
        // early RLAST on beat 1 of a 4-beat burst
        run_read(32'h0000_0200, 4'd3, 1, 2, 32'h10, 1'b0, 1'b1);
        // missing RLAST on the expected last beat, slave ends one beat late
        run_read(32'h0000_0300, 4'd1, 1, 3, 32'h20, 1'b0, 1'b1);
        // maximum 16-beat burst
        run_read(32'h0000_0400, 4'd15, 1, 16, 32'h100, 1'b0, 1'b0);

        // back-to-back: req_valid stays high from a write into a read
        drive_req(1'b1, 32'h0000_0040, 4'h0, 32'hFEED_0001, 4'hF);
        #1 check_val("b2b_ready0", req_ready, 1'b1);
        tick();
        drive_req(1'b0, 32'h0000_0080, 4'd0, 32'h0, 4'h0);
        M_AWREADY = 1'b1;
        #1;
        check_val("b2b_awvalid", M_AWVALID, 1'b1);
        check_val("b2b_no_ar", M_ARVALID, 1'b0);
        check_val("b2b_busy", req_ready, 1'b0);
        tick();
        M_AWREADY = 1'b0; M_WREADY = 1'b1;
        #1;
        check_val("b2b_wvalid", M_WVALID, 1'b1);
        check_val("b2b_no_ar_w", M_ARVALID, 1'b0);
        tick();
        M_WREADY = 1'b0; M_BVALID = 1'b1;
        #1;
        check_val("b2b_wr_done", rsp_done, 1'b1);
        check_val("b2b_busy_done", req_ready, 1'b0);
        tick();
        M_BVALID = 1'b0;
        #1;
        check_val("b2b_ready1", req_ready, 1'b1);
        check_val("b2b_idle_ar", M_ARVALID, 1'b0);
        check_val("b2b_idle_aw", M_AWVALID, 1'b0);
        tick();
        req_valid = 1'b0; M_ARREADY = 1'b1;
        #1;
        check_val("b2b_arvalid", M_ARVALID, 1'b1);
        check_val("b2b_araddr", M_ARADDR, 32'h0000_0080);
        check_val("b2b_no_aw_r", M_AWVALID, 1'b0);
        tick();
        M_ARREADY = 1'b0; M_RVALID = 1'b1; M_RDATA = 32'hCAFE_0001; M_RLAST = 1'b1;
        #1;
        check_val("b2b_rd_done", rsp_done, 1'b1);
        check_val("b2b_rd_data", rsp_rdata, 32'hCAFE_0001);
        tick();
        clear_slave();

        // reset asserted while beat 2 of a 4-beat read is presented
        drive_req(1'b0, 32'h0000_0500, 4'd3, 32'h0, 4'h0);
        tick();
        req_valid = 1'b0; M_ARREADY = 1'b1;
        tick();
        M_ARREADY = 1'b0;
        for (int b = 0; b < 2; b++) begin
            M_RVALID = 1'b1; M_RDATA = 32'h50 + 32'(b); M_RLAST = 1'b0;
            #1 check_val("rst6_beat", rsp_rvalid, 1'b1);
            tick();
        end
        M_RDATA = 32'h52; ARESETn = 1'b0;
        #1 check_val("rst6_no_done_pre", rsp_done, 1'b0);
        tick();
        #1;
        check_val("rst6_rready", M_RREADY, 1'b0);
        check_val("rst6_arvalid", M_ARVALID, 1'b0);
        check_val("rst6_rvalid", rsp_rvalid, 1'b0);
        check_val("rst6_no_done", rsp_done, 1'b0);
        tick();
        ARESETn = 1'b1;
        clear_slave();
        #1 check_val("rst6_ready", req_ready, 1'b1);
        run_read(32'h0000_0600, 4'd1, 1, 2, 32'h77, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
